// File: rtl/sata_link_pm_requester.sv
// SATA link power-management requester: sends PMREQ_P/PMREQ_S, qualifies the
// far end's PMACK/PMNACK, and holds the phy in partial/slumber until a wake request.
module sata_link_pm_requester #(
    parameter int RESP_TIMEOUT = 2048,
    parameter int ACK_MIN      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        phy_ready,
    input  logic        link_idle,
    input  logic        is_device,
    input  logic        pm_request,
    input  logic        pm_slumber,
    input  logic        pm_wake,
    input  logic        detect_pmack,
    input  logic        detect_pmnack,
    input  logic        detect_x_rdy,
    input  logic        detect_preq_s,
    input  logic        detect_preq_p,
    output logic [31:0] tx_dout,
    output logic        tx_is_k,
    output logic        tx_active,
    output logic        phy_pm_partial,
    output logic        phy_pm_slumber,
    output logic        phy_wake,
    output logic        pm_ack,
    output logic        pm_nack,
    output logic        pm_timeout,
    output logic        pm_active,
    output logic [3:0]  state
);

    localparam logic [31:0] PRIM_SYNC    = 32'hB5B5_957C;
    localparam logic [31:0] PRIM_PMREQ_P = 32'h1717_B57C;
    localparam logic [31:0] PRIM_PMREQ_S = 32'h7575_957C;

    localparam int CW = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
    localparam int AW = (ACK_MIN > 0) ? $clog2(ACK_MIN + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(RESP_TIMEOUT - 1);
    localparam logic [AW-1:0] ACK_TGT = AW'(ACK_MIN);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_SEND_REQ  = 4'd1,
        S_ACK_WAIT  = 4'd2,
        S_BACKOFF   = 4'd3,
        S_PM_ACTIVE = 4'd4,
        S_WAKE      = 4'd5
    } pm_state_t;

    pm_state_t      cur_st, nxt_st;
    logic           slumber_r, slumber_nx;
    logic [CW-1:0]  to_cnt, to_cnt_nx;
    logic [AW-1:0]  ack_cnt, ack_cnt_nx, ack_inc;
    logic           seen_low, seen_low_nx;
    logic           wake_cnt, wake_cnt_nx;
    logic           ack_s, nack_s, to_s, wake_s;
    logic           collide;
    logic           req_tx_nx;

    assign state   = cur_st;
    assign tx_is_k = 1'b1;
    assign ack_inc = ack_cnt + AW'(1);
    // A host wins PREQ collisions; only X_RDY forces it to back off.
    assign collide = detect_x_rdy | (is_device & (detect_preq_s | detect_preq_p));

    always_comb begin
        nxt_st      = cur_st;
        slumber_nx  = slumber_r;
        to_cnt_nx   = to_cnt;
        ack_cnt_nx  = ack_cnt;
        seen_low_nx = seen_low;
        wake_cnt_nx = wake_cnt;
        ack_s       = 1'b0;
        nack_s      = 1'b0;
        to_s        = 1'b0;
        wake_s      = 1'b0;
        case (cur_st)
            S_IDLE: begin
                if (pm_request) begin
                    if (phy_ready && link_idle) begin
                        nxt_st     = S_SEND_REQ;
                        slumber_nx = pm_slumber;
                        to_cnt_nx  = '0;
                    end else begin
                        nack_s = 1'b1;
                    end
                end
            end
            S_SEND_REQ: begin
                if (to_cnt != '1)
                    to_cnt_nx = to_cnt + CW'(1);
                if (!phy_ready) begin
                    nack_s = 1'b1;
                    nxt_st = S_IDLE;
                end else if (detect_pmack) begin
                    if (ACK_MIN <= 1) begin
                        ack_s  = 1'b1;
                        nxt_st = S_PM_ACTIVE;
                    end else begin
                        ack_cnt_nx = AW'(1);
                        nxt_st     = S_ACK_WAIT;
                    end
                end else if (detect_pmnack || collide) begin
                    nack_s = 1'b1;
                    nxt_st = S_BACKOFF;
                end else if (to_cnt >= TO_LAST) begin
                    to_s   = 1'b1;
                    nxt_st = S_BACKOFF;
                end
            end
            S_ACK_WAIT: begin
                if (!phy_ready) begin
                    nack_s = 1'b1;
                    nxt_st = S_IDLE;
                end else if (detect_pmack) begin
                    ack_cnt_nx = ack_inc;
                    if (ack_inc >= ACK_TGT) begin
                        ack_s  = 1'b1;
                        nxt_st = S_PM_ACTIVE;
                    end
                end else begin
                    // Broken ack run: start qualifying again, timeout keeps its progress.
                    ack_cnt_nx = '0;
                    nxt_st     = S_SEND_REQ;
                end
            end
            S_BACKOFF: nxt_st = S_IDLE;
            S_PM_ACTIVE: begin
                if (pm_wake) begin
                    wake_s      = 1'b1;
                    seen_low_nx = 1'b0;
                    wake_cnt_nx = 1'b0;
                    nxt_st      = S_WAKE;
                end
            end
            S_WAKE: begin
                wake_cnt_nx = 1'b1;
                if (!phy_ready)
                    seen_low_nx = 1'b1;
                else if (seen_low || wake_cnt)
                    nxt_st = S_IDLE;
            end
            default: nxt_st = S_IDLE;
        endcase
    end

    assign req_tx_nx = (nxt_st == S_SEND_REQ) || (nxt_st == S_ACK_WAIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_st         <= S_IDLE;
            slumber_r      <= 1'b0;
            to_cnt         <= '0;
            ack_cnt        <= '0;
            seen_low       <= 1'b0;
            wake_cnt       <= 1'b0;
            tx_dout        <= PRIM_SYNC;
            tx_active      <= 1'b0;
            phy_pm_partial <= 1'b0;
            phy_pm_slumber <= 1'b0;
            phy_wake       <= 1'b0;
            pm_ack         <= 1'b0;
            pm_nack        <= 1'b0;
            pm_timeout     <= 1'b0;
            pm_active      <= 1'b0;
        end else begin
            cur_st         <= nxt_st;
            slumber_r      <= slumber_nx;
            to_cnt         <= to_cnt_nx;
            ack_cnt        <= ack_cnt_nx;
            seen_low       <= seen_low_nx;
            wake_cnt       <= wake_cnt_nx;
            // Outputs follow the next state so they line up with the state register.
            tx_dout        <= req_tx_nx ? (slumber_nx ? PRIM_PMREQ_S : PRIM_PMREQ_P) : PRIM_SYNC;
            tx_active      <= (nxt_st != S_IDLE);
            phy_pm_partial <= (nxt_st == S_PM_ACTIVE) && !slumber_nx;
            phy_pm_slumber <= (nxt_st == S_PM_ACTIVE) && slumber_nx;
            phy_wake       <= wake_s;
            pm_ack         <= ack_s;
            pm_nack        <= nack_s;
            pm_timeout     <= to_s;
            pm_active      <= (nxt_st == S_PM_ACTIVE);
        end
    end

endmodule
